// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and access-error rule for the data-memory responder
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Misaligned, illegal-size and out-of-range accesses are all rejected the same way.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic [31:0] w_word_idx;
    w_word_idx = {2'b00, addr[31:2]};
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = addr[0];
      SZ_WORD: access_err = (addr[1:0] != 2'b00);
      default: access_err = 1'b1;
    endcase
    if (w_word_idx >= depth_words) access_err = 1'b1;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte/half/word lane merge for stores and extract/extend for loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_new_word,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_new_word = i_word;
    case (i_size)
      SZ_BYTE: o_new_word[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_new_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      SZ_WORD: o_new_word = i_wdata;
      default: o_new_word = i_word;
    endcase
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_size)
      SZ_BYTE: o_rdata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      SZ_WORD: o_rdata = i_word;
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory slave with programmable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_do_access;
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [1:0]  w_acc_size;
  logic        w_acc_unsigned;
  logic [31:0] w_acc_wdata;
  logic        w_acc_err;
  logic [IW-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_new_word;
  logic [31:0] w_load_data;

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  // With zero wait states the access lands on the accept edge, so it must use the live request.
  assign w_do_access    = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd1));
  assign w_acc_we       = (r_state == ST_IDLE) ? req_we       : r_we;
  assign w_acc_addr     = (r_state == ST_IDLE) ? req_addr     : r_addr;
  assign w_acc_size     = (r_state == ST_IDLE) ? req_size     : r_size;
  assign w_acc_unsigned = (r_state == ST_IDLE) ? req_unsigned : r_unsigned;
  assign w_acc_wdata    = (r_state == ST_IDLE) ? req_wdata    : r_wdata;

  assign w_acc_err = access_err(w_acc_size, w_acc_addr, DEPTH_WORDS);
  assign w_idx     = w_acc_addr[IW+1:2];
  assign w_word    = r_mem[w_idx];

  dmem_lane_align u_align (
    .i_word     (w_word),
    .i_wdata    (w_acc_wdata),
    .i_addr_lo  (w_acc_addr[1:0]),
    .i_size     (w_acc_size),
    .i_unsigned (w_acc_unsigned),
    .o_new_word (w_new_word),
    .o_rdata    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset && w_do_access && !w_acc_err && w_acc_we) begin
      r_mem[w_idx] <= w_new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_cnt      <= WAIT_LOAD;
            r_state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= 4'(r_cnt - 4'd1);
          if (r_cnt == 4'd1) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_do_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_acc_err;
        r_rsp_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : w_load_data;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (2 and 0 wait states)
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_we, req_unsigned, rsp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [31:0] rd_a, rd_b;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(vld_a), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd_a), .rsp_err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(vld_b), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd_b), .rsp_err(err_b)
  );

  assign o_req_ready = sel ? rdy_b : rdy_a;
  assign o_rsp_valid = sel ? vld_b : vld_a;
  assign o_rsp_rdata = sel ? rd_b  : rd_a;
  assign o_rsp_err   = sel ? err_b : err_a;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  m [2][1024];
  logic        exp_err;
  logic [31:0] exp_rd;
  logic        got_err;
  logic [31:0] got_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed little-endian reference memory, one per instance.
  function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
    int n;
    logic [63:0] v, mask;
    n = 1 << size;
    err = (size == 2'b11) || ((addr % n) != 0) || (addr >= 32'd1024);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) m[d][addr + i] = wdata[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(m[d][addr + i]) << (8 * i));
      mask = (64'd1 << (8 * n)) - 64'd1;
      if (!uns && v[8*n-1]) v = v | ~mask;
      rd = v[31:0];
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic hold);
    chk("issue_ready", {31'd0, o_req_ready}, 32'd1);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    model(sel ? 1 : 0, we, addr, size, uns, wdata, exp_err, exp_rd);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int stall);
    int lat;
    lat = 0;
    while (!o_rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), sel ? 32'd0 : 32'd2);
    got_rd = o_rsp_rdata;
    got_err = o_rsp_err;
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, got_rd, exp_rd);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {o_rsp_valid, o_req_ready, o_rsp_err}, {1'b1, 1'b0, got_err});
      chk({tag, "_hold_rd"}, o_rsp_rdata, got_rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
  endtask

  logic [7:0]  saved [4];
  logic [31:0] a;
  logic [1:0]  sz;

  initial begin
    sel = 1'b0; reset = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {o_rsp_valid, o_rsp_err, o_rsp_rdata[29:0]}, 32'd0);
    chk("rst_rdata", o_rsp_rdata, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_idle", {30'd0, o_req_ready, o_rsp_valid}, 32'd2);
    @(posedge clk); #1;
    chk("rst_no_rsp", {31'd0, o_rsp_valid}, 32'd0);

    for (int w = 0; w < 256; w++) begin
      issue(1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b0);
      collect("init_a", 0);
    end
    sel = 1'b1;
    for (int w = 0; w < 16; w++) begin
      issue(1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom, 1'b0);
      collect("init_b", 0);
    end
    issue(1'b1, 32'h3FC, 2'b10, 1'b0, $urandom, 1'b0);
    collect("init_b", 0);
    sel = 1'b0;

    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0); collect("t1_sw", 0);
    chk("t1_sw_err", {31'd0, got_err}, 32'd0);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b0); collect("t1_lw", 0);
    chk("t1_lw_val", got_rd, 32'hDEADBEEF);

    issue(1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 1'b0); collect("t2_sb", 0);
    issue(1'b0, 32'h13, 2'b00, 1'b0, 32'd0, 1'b0); collect("t2_lb", 0);
    chk("t2_lb_val", got_rd, 32'hFFFFFF80);
    issue(1'b0, 32'h13, 2'b00, 1'b1, 32'd0, 1'b0); collect("t2_lbu", 0);
    chk("t2_lbu_val", got_rd, 32'h00000080);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b0); collect("t2_lw", 0);
    chk("t2_lw_val", got_rd, 32'h80ADBEEF);

    issue(1'b1, 32'h11, 2'b01, 1'b0, 32'h5555, 1'b0); collect("t3_sh", 0);
    chk("t3_sh_errval", {got_err, got_rd[30:0]}, 32'h80000000);
    issue(1'b1, 32'h12, 2'b10, 1'b0, 32'h66666666, 1'b0); collect("t3_sw", 0);
    chk("t3_sw_errval", {got_err, got_rd[30:0]}, 32'h80000000);
    issue(1'b0, 32'h10, 2'b11, 1'b0, 32'd0, 1'b0); collect("t3_sz3", 0);
    chk("t3_sz3_errval", {got_err, got_rd[30:0]}, 32'h80000000);
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b0); collect("t3_lw", 0);
    chk("t3_lw_val", got_rd, 32'h80ADBEEF);

    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b1);
    req_addr = 32'h14;
    collect("t4_stall", 5);
    model(0, 1'b0, 32'h14, 2'b10, 1'b0, 32'd0, exp_err, exp_rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_next_accepted", {31'd0, o_req_ready}, 32'd0);
    collect("t4_next", 0);

    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'h11111111, 1'b0); collect("t5_sw1", 0);
    for (int i = 0; i < 4; i++) saved[i] = m[0][32'h20 + i];
    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, 1'b0);
    for (int i = 0; i < 4; i++) m[0][32'h20 + i] = saved[i];
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_after_rst", {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_late_rsp", {31'd0, o_rsp_valid}, 32'd0);
    issue(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 1'b0); collect("t5_lw", 0);
    chk("t5_lw_val", got_rd, 32'h11111111);

    issue(1'b0, 32'h400, 2'b10, 1'b0, 32'd0, 1'b0); collect("t6_oor", 0);
    chk("t6_oor_err", {31'd0, got_err}, 32'd1);
    sel = 1'b1;
    issue(1'b0, 32'h3FC, 2'b10, 1'b0, 32'd0, 1'b0); collect("t6_w0", 0);
    chk("t6_w0_err", {31'd0, got_err}, 32'd0);
    sel = 1'b0;

    for (int k = 0; k < 90; k++) begin
      sel = (k >= 60);
      a  = sel ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 1050));
      sz = 2'($urandom_range(0, 3));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      collect("rnd", $urandom_range(0, 2));
    end
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
